vga_char_fetch: RTL and testbench

- Text-mode pixel engine; the reading side of the character font ROM.
- Tracks the raster position from VGA timing inputs and reads a character code from the text buffer RAM.
- Issues the glyph-row address to the font ROM, then serialises the returned 12-bit glyph row into RGB pixels.
- Sits between the VGA timing generator and the VGA output pins. Glyph cell is 12×16; font ROM holds 256 glyphs × 16 rows (4096 × 12 bits).

---
 rtl/vga_char_fetch.sv | 116 +++++++++++
 tb/tb_vga_char_fetch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_char_fetch.sv
// Text-mode pixel engine: tracks raster position, fetches a character code from the
// text buffer, then a glyph row from the font ROM, and serialises it into RGB444 pixels.
module vga_char_fetch #(
  parameter int          COLS     = 53,
  parameter int          ROWS     = 30,
  parameter int          TADDR_W  = 11,
  parameter logic [11:0] FG       = 12'hFFF,
  parameter logic [11:0] BG       = 12'h000,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               hs_in,
  input  logic               vs_in,
  output logic [TADDR_W-1:0] text_addr,
  input  logic [7:0]         text_q,
  output logic [11:0]        font_addr,
  input  logic [11:0]        font_q,
  output logic [11:0]        rgb_out,
  output logic               de_out,
  output logic               hs_out,
  output logic               vs_out
);

  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [COL_W-1:0]   COL_MAX  = COL_W'(COLS);
  localparam logic [ROW_W-1:0]   ROW_MAX  = ROW_W'(ROWS);
  localparam logic [TADDR_W-1:0] ROW_STEP = TADDR_W'(COLS);

  // Per-pixel side information that must stay aligned with the two memory reads.
  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       blank;
    logic [3:0] px;
    logic [3:0] py;
  } stage_t;

  // The pipeline is free-running: one pixel enters and one leaves every clock,
  // with no valid/ready handshake and no stall path.
  stage_t             st [4];
  logic [3:0]         px;
  logic [3:0]         py;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic [TADDR_W-1:0] row_base;
  logic               frame_ok;
  logic               blank;
  logic               line_end;

  assign blank    = (col == COL_MAX) | (row == ROW_MAX) | ~frame_ok;
  assign line_end = st[0].de & ~de_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      px        <= 4'd0;
      py        <= 4'd0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      frame_ok  <= 1'b0;
      text_addr <= '0;
      font_addr <= 12'd0;
      rgb_out   <= BG;
      de_out    <= 1'b0;
      hs_out    <= ~SYNC_POL;
      vs_out    <= ~SYNC_POL;
      for (int i = 0; i < 4; i++) begin
        st[i] <= '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL, blank: 1'b0, px: 4'd0, py: 4'd0};
      end
    end else begin
      // Stage 1: text buffer address plus captured position/timing.
      if (!blank) text_addr <= row_base + TADDR_W'(col);
      st[0] <= '{de: de_in, hs: hs_in, vs: vs_in, blank: blank, px: px, py: py};
      for (int i = 1; i < 4; i++) st[i] <= st[i-1];

      // Stage 3: text_q has arrived; form the glyph-row address.
      font_addr <= {text_q, st[1].py};

      // Stage 5: font_q has arrived; bit 11 is the leftmost pixel of the cell.
      rgb_out <= (st[3].de & ~st[3].blank & font_q[4'd11 - st[3].px]) ? FG : BG;
      de_out  <= st[3].de;
      hs_out  <= st[3].hs;
      vs_out  <= st[3].vs;

      // Raster position; vsync clear beats everything, line end beats pixel advance.
      if (vs_in == SYNC_POL) begin
        px       <= 4'd0;
        col      <= '0;
        py       <= 4'd0;
        row      <= '0;
        row_base <= '0;
        frame_ok <= 1'b1;
      end else if (line_end) begin
        px  <= 4'd0;
        col <= '0;
        py  <= py + 4'd1;
        if (py == 4'd15 && row != ROW_MAX) begin
          row      <= row + ROW_W'(1);
          row_base <= row_base + ROW_STEP;
        end
      end else if (de_in) begin
        if (px == 4'd11) begin
          px <= 4'd0;
          if (col != COL_MAX) col <= col + COL_W'(1);
        end else begin
          px <= px + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_char_fetch.sv
// Bench for vga_char_fetch: drives short/full raster lines, models the text RAM and font
// ROM, and checks pixel, sync and address outputs against an expected queue.
module tb_vga_char_fetch;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [10:0] text_addr;
  logic [7:0]  text_q;
  logic [11:0] font_addr;
  logic [11:0] font_q;
  logic [11:0] rgb_out;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  always #5 clk = ~clk;

  vga_char_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .de_in     (de_in),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .text_addr (text_addr),
    .text_q    (text_q),
    .font_addr (font_addr),
    .font_q    (font_q),
    .rgb_out   (rgb_out),
    .de_out    (de_out),
    .hs_out    (hs_out),
    .vs_out    (vs_out)
  );

  // ---------------- memory stubs ----------------
  bit font_force = 1'b0;

  function automatic logic [7:0] text_fn(input logic [10:0] a);
    return (a == 11'd54) ? 8'h41 : (a[7:0] ^ 8'h5A);
  endfunction

  function automatic logic [11:0] font_fn(input logic [11:0] a, input bit frc);
    if (frc) return 12'hFFF;
    if (a == 12'h412) return 12'hA50;
    return {a[3:0], a[11:4]} ^ 12'h6C3;
  endfunction

  always @(posedge clk) begin
    text_q <= text_fn(text_addr);
    font_q <= font_fn(font_addr, font_force);
  end

  // ---------------- clock/cycle count ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [46:0] exp_q [$];  // {tag, de, hs, vs, rgb}
  logic [42:0] ta_q  [$];  // {tag, text_addr}
  logic [43:0] fa_q  [$];  // {tag, font_addr}
  int n_cmp  = 0;
  int n_fail = 0;

  int y      = 0;
  bit fok_m  = 1'b0;
  int last_ta = 0;

  logic [11:0] a50_seq [12] = '{12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF,
                                12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000};

  function automatic logic [11:0] exp_rgb(input bit de, input int x, input int yy,
                                          input bit fok, input bit frc);
    int a;
    logic [11:0] g;
    if (!de || !fok || x >= 636 || yy >= 480) return BG;
    a = (yy / 16) * 53 + x / 12;
    g = font_fn({text_fn(11'(a)), 4'(yy % 16)}, frc);
    return g[11 - (x % 12)] ? FG : BG;
  endfunction

  // ---------------- monitor ----------------
  logic [46:0] m_e;
  logic [42:0] m_t;
  logic [43:0] m_f;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q[0];
      if (int'(m_e[46:15]) + 4 <= cyc) begin
        void'(exp_q.pop_front());
        n_cmp++;
        if (int'(m_e[46:15]) + 4 != cyc) begin
          n_fail++;
          $display("FAIL pix_order tag=%0d seen at cyc=%0d", m_e[46:15], cyc);
        end else if ({de_out, hs_out, vs_out, rgb_out} !== m_e[14:0]) begin
          n_fail++;
          $display("FAIL pixel tag=%0d got de=%b hs=%b vs=%b rgb=%h want de=%b hs=%b vs=%b rgb=%h",
                   m_e[46:15], de_out, hs_out, vs_out, rgb_out,
                   m_e[14], m_e[13], m_e[12], m_e[11:0]);
        end
      end
    end
    if (ta_q.size() > 0) begin
      m_t = ta_q[0];
      if (int'(m_t[42:11]) <= cyc) begin
        void'(ta_q.pop_front());
        n_cmp++;
        if (text_addr !== m_t[10:0]) begin
          n_fail++;
          $display("FAIL text_addr tag=%0d got %0d want %0d", m_t[42:11], text_addr, m_t[10:0]);
        end
      end
    end
    if (fa_q.size() > 0) begin
      m_f = fa_q[0];
      if (int'(m_f[43:12]) + 2 <= cyc) begin
        void'(fa_q.pop_front());
        n_cmp++;
        if (font_addr !== m_f[11:0]) begin
          n_fail++;
          $display("FAIL font_addr tag=%0d got %h want %h", m_f[43:12], font_addr, m_f[11:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string nm, input logic [11:0] got, input logic [11:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic drive(input bit de, input bit hs, input bit vs, input int x);
    logic [11:0] rgb;
    logic [11:0] fa;
    int ta;
    @(negedge clk);
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    rgb = exp_rgb(de, x, y, fok_m, font_force);
    if (de && fok_m && y == 18 && x >= 12 && x < 24) rgb = a50_seq[x-12];
    exp_q.push_back({32'(cyc + 1), de, hs, vs, rgb});
    if (de && fok_m && y < 480) begin
      if (x < 636) begin
        ta = (y / 16) * 53 + x / 12;
        fa = {text_fn(11'(ta)), 4'(y % 16)};
        if (y >= 16 && y < 32 && x >= 12 && x < 24) begin
          ta = 54;
          fa = 12'h410 + 12'(y - 16);
        end
        if (y == 464 && x >= 624) ta = 1589;
        last_ta = ta;
        ta_q.push_back({32'(cyc + 1), 11'(ta)});
        fa_q.push_back({32'(cyc + 1), fa});
      end else begin
        ta_q.push_back({32'(cyc + 1), 11'(last_ta)});
      end
    end
    if (vs == 1'b0) begin
      fok_m = 1'b1;
      y = 0;
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((exp_q.size() > 0 || ta_q.size() > 0 || fa_q.size() > 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain got %0d entries left want 0", exp_q.size() + ta_q.size() + fa_q.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      de_in = 1'($urandom_range(0, 1));
      hs_in = 1'($urandom_range(0, 1));
      vs_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("rst_rgb",       rgb_out,          12'h000);
    check("rst_de",        12'(de_out),      12'h0);
    check("rst_hs",        12'(hs_out),      12'h1);
    check("rst_vs",        12'(vs_out),      12'h1);
    check("rst_text_addr", 12'(text_addr),   12'h0);
    check("rst_font_addr", font_addr,        12'h0);
    de_in = 1'b0;
    hs_in = 1'b1;
    vs_in = 1'b1;
    rst_n = 1'b1;
    fok_m = 1'b0;
    last_ta = 0;
  endtask

  task automatic line(input int width);
    for (int x = 0; x < width; x++) drive(1'b1, 1'b1, 1'b1, x);
    drive(1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
    y++;
  endtask

  task automatic vsync();
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
    drive(1'b0, 1'b1, 1'b1, 0);
  endtask

  function automatic int width_for(input int yy);
    if (yy == 0) return 30;
    if (yy == 18 || yy == 464) return 640;
    if (yy >= 16 && yy < 32) return 24;
    if (yy >= 480) return 20;
    return 3;
  endfunction

  task automatic frame(input int last_line, input int reset_at);
    vsync();
    while (y <= last_line) begin
      if (y == reset_at) begin
        drain();
        do_reset();
      end
      font_force = (y == 464 || y >= 480);
      line(width_for(y));
    end
    font_force = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    frame(481, -1);
    frame(481, 100);
    frame(40, -1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
